// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver, mid-bit sampling, AXI-stream byte output.
// Optional macro UART_RX_SYNC_EN adds a two-flop rxd synchronizer.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error,
   input  logic [15:0]           prescale
);

   localparam int BW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                r_state;
   state_t                w_state_n;
   logic [18:0]           r_cnt;
   logic [18:0]           w_cnt_n;
   logic [BW-1:0]         r_bits;
   logic [BW-1:0]         w_bits_n;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_n;
   logic [DATA_WIDTH-1:0] r_tdata;
   logic [DATA_WIDTH-1:0] w_tdata_n;
   logic                  r_tvalid;
   logic                  w_tvalid_n;
   logic                  r_busy;
   logic                  w_busy_n;
   logic                  r_ovr;
   logic                  w_ovr_n;
   logic                  r_fe;
   logic                  w_fe_n;
   logic                  r_armed;
   logic                  w_armed_n;
   logic                  r_rxd_reg;
   logic                  w_rxd_in;
   logic [18:0]           w_ps;
   logic [18:0]           w_ld_start;
   logic [18:0]           w_ld_bit;

   assign w_ps       = {3'b000, prescale};
   assign w_ld_start = (w_ps << 2) - 19'd2;
   assign w_ld_bit   = (w_ps << 3) - 19'd1;

`ifdef UART_RX_SYNC_EN
   logic [1:0] r_sync;

   // two-flop metastability guard ahead of the sampling register
   always_ff @(posedge clk) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], rxd};
   end

   assign w_rxd_in = r_sync[1];
`else
   assign w_rxd_in = rxd;
`endif

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bits    <= '0;
         r_shift   <= '0;
         r_tdata   <= '0;
         r_tvalid  <= 1'b0;
         r_busy    <= 1'b0;
         r_ovr     <= 1'b0;
         r_fe      <= 1'b0;
         r_armed   <= 1'b0;
         r_rxd_reg <= 1'b1;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_bits    <= w_bits_n;
         r_shift   <= w_shift_n;
         r_tdata   <= w_tdata_n;
         r_tvalid  <= w_tvalid_n;
         r_busy    <= w_busy_n;
         r_ovr     <= w_ovr_n;
         r_fe      <= w_fe_n;
         r_armed   <= w_armed_n;
         r_rxd_reg <= w_rxd_in;
      end
   end

   // next-state: start detect, bit timing, delivery and handshake
   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_bits_n   = r_bits;
      w_shift_n  = r_shift;
      w_tdata_n  = r_tdata;
      w_tvalid_n = r_tvalid && !m_axis_tready;
      w_busy_n   = r_busy;
      w_ovr_n    = 1'b0;
      w_fe_n     = 1'b0;
      w_armed_n  = r_armed;
      unique case (r_state)
         S_IDLE: begin
            if (r_rxd_reg) begin
               w_armed_n = 1'b1;
            end else if (r_armed) begin
               w_cnt_n   = w_ld_start;
               w_busy_n  = 1'b1;
               w_state_n = S_START;
            end
         end
         S_START: begin
            if (r_cnt != '0) begin
               w_cnt_n = r_cnt - 19'd1;
            end else if (!r_rxd_reg) begin
               w_cnt_n   = w_ld_bit;
               w_bits_n  = BW'(DATA_WIDTH);
               w_state_n = S_DATA;
            end else begin
               // start bit vanished: treat as a glitch
               w_busy_n  = 1'b0;
               w_state_n = S_IDLE;
            end
         end
         S_DATA: begin
            if (r_cnt != '0) begin
               w_cnt_n = r_cnt - 19'd1;
            end else begin
               w_shift_n = DATA_WIDTH'({r_rxd_reg, r_shift} >> 1);
               w_bits_n  = r_bits - BW'(1);
               w_cnt_n   = w_ld_bit;
               if (r_bits == BW'(1)) w_state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (r_cnt != '0) begin
               w_cnt_n = r_cnt - 19'd1;
            end else begin
               w_busy_n  = 1'b0;
               w_state_n = S_IDLE;
               if (r_rxd_reg) begin
                  w_tdata_n  = r_shift;
                  w_tvalid_n = 1'b1;
                  w_ovr_n    = r_tvalid && !m_axis_tready;
               end else begin
                  // disarm so a held-low line gives one error only
                  w_fe_n    = 1'b1;
                  w_armed_n = 1'b0;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign busy          = r_busy;
   assign overrun_error = r_ovr;
   assign frame_error   = r_fe;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level event model of uart_rx.
// Honours UART_RX_SYNC_EN by shifting all expected timing by two clocks.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        rxd = 1'b1;
   logic        busy;
   logic        overrun_error;
   logic        frame_error;
   logic [15:0] prescale = 16'd1;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .rxd           (rxd),
      .busy          (busy),
      .overrun_error (overrun_error),
      .frame_error   (frame_error),
      .prescale      (prescale)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   // kind: 0 glitch, 1 good byte, 2 framing error
   typedef struct {
      int         st;
      int         done;
      int         kind;
      logic [7:0] d;
   } ev_t;

   ev_t evq[$];

   bit         mv = 1'b0;
   logic [7:0] md = 8'h00;
   bit         rdy_prev = 1'b1;
   bit         rst_prev = 1'b1;
   bit         tv_prev = 1'b0;
   int         cnt_ovr = 0;
   int         cnt_fe = 0;
   int         cnt_rise = 0;
   int         cnt_busy = 0;
   int         last_rise = 0;
   logic [7:0] rise_data = 8'h00;

   // model step and per-cycle comparison
   always @(negedge clk) begin
      bit         dlv;
      bit         fe;
      bit         bz;
      bit         eo;
      logic [7:0] dd;
      dlv = 1'b0;
      fe  = 1'b0;
      bz  = 1'b0;
      eo  = 1'b0;
      dd  = 8'h00;
      if (rst_prev) begin
         mv = 1'b0;
         md = 8'h00;
         evq.delete();
      end else begin
         foreach (evq[i]) begin
            if (evq[i].done == cyc) begin
               if (evq[i].kind == 1) begin
                  dlv = 1'b1;
                  dd  = evq[i].d;
               end else if (evq[i].kind == 2) begin
                  fe = 1'b1;
               end
            end
            if (cyc >= evq[i].st && cyc < evq[i].done) bz = 1'b1;
         end
         while (evq.size() > 0 && evq[0].done < cyc) void'(evq.pop_front());
         eo = dlv && mv && !rdy_prev;
         if (dlv) begin
            mv = 1'b1;
            md = dd;
         end else if (mv && rdy_prev) begin
            mv = 1'b0;
         end
      end
      chk("tvalid", 32'(m_axis_tvalid), 32'(mv));
      chk("tdata", 32'(m_axis_tdata), 32'(md));
      chk("busy", 32'(busy), 32'(bz));
      chk("overrun", 32'(overrun_error), 32'(eo));
      chk("frame_err", 32'(frame_error), 32'(fe));
      if (overrun_error === 1'b1) cnt_ovr++;
      if (frame_error === 1'b1) cnt_fe++;
      if (busy === 1'b1) cnt_busy++;
      if (m_axis_tvalid === 1'b1 && !tv_prev) begin
         cnt_rise++;
         last_rise = cyc;
         rise_data = m_axis_tdata;
      end
      tv_prev  = (m_axis_tvalid === 1'b1);
      rdy_prev = m_axis_tready;
      rst_prev = rst;
   end

   task automatic wait_cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // drives one 10-bit frame; rst_bit>=0 pulses rst mid-way through that bit
   task automatic send(input logic [7:0] d, input bit stopb, input int p,
                       input int rst_bit);
      int       n;
      logic [9:0] fr;
      ev_t      e;
      n      = cyc;
      fr     = {stopb, d, 1'b0};
      e.st   = n + 2 + S;
      e.done = n + 4 * p + 1 + 8 * p * 9 + S;
      e.kind = stopb ? 1 : 2;
      e.d    = d;
      evq.push_back(e);
      for (int j = 0; j < 10; j++) begin
         rxd = fr[j];
         for (int k = 0; k < 8 * p; k++) begin
            rst = (j == rst_bit && k == 4 * p);
            @(posedge clk);
            #1;
         end
      end
      rst = 1'b0;
   endtask

   task automatic glitch(input int p);
      ev_t e;
      e.st   = cyc + 2 + S;
      e.done = cyc + 4 * p + 1 + S;
      e.kind = 0;
      e.d    = 8'h00;
      evq.push_back(e);
      rxd = 1'b0;
      wait_cyc(2);
      rxd = 1'b1;
   endtask

   initial begin
      int n0;
      int o0;
      int f0;
      int r0;
      int b0;
      wait_cyc(3);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_cyc(5);

      // single byte, sink always ready
      prescale = 16'd1;
      m_axis_tready = 1'b1;
      o0 = cnt_ovr; f0 = cnt_fe; r0 = cnt_rise;
      n0 = cyc;
      send(8'hA5, 1'b1, 1, -1);
      wait_cyc(10);
      chk("a5_rises", 32'(cnt_rise - r0), 32'd1);
      chk("a5_data", 32'(rise_data), 32'hA5);
      chk("a5_latency", 32'(last_rise - n0), 32'(77 + S));
      chk("a5_ovr", 32'(cnt_ovr - o0), 32'd0);
      chk("a5_fe", 32'(cnt_fe - f0), 32'd0);

      // two bytes back-to-back into a stalled sink
      m_axis_tready = 1'b0;
      o0 = cnt_ovr;
      send(8'h3C, 1'b1, 1, -1);
      send(8'h81, 1'b1, 1, -1);
      wait_cyc(5);
      chk("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("ovr_tdata", 32'(m_axis_tdata), 32'h81);
      chk("ovr_count", 32'(cnt_ovr - o0), 32'd1);
      m_axis_tready = 1'b1;
      wait_cyc(3);
      chk("ovr_drain", 32'(m_axis_tvalid), 32'd0);

      // bad stop bit followed by a long break
      prescale = 16'd2;
      f0 = cnt_fe; r0 = cnt_rise;
      send(8'h55, 1'b0, 2, -1);
      wait_cyc(200);
      chk("brk_fe", 32'(cnt_fe - f0), 32'd1);
      chk("brk_rises", 32'(cnt_rise - r0), 32'd0);
      rxd = 1'b1;
      wait_cyc(20);

      // short low glitch is rejected
      prescale = 16'd1;
      f0 = cnt_fe; r0 = cnt_rise; b0 = cnt_busy; o0 = cnt_ovr;
      glitch(1);
      wait_cyc(20);
      chk("gl_busy_cycles", 32'(cnt_busy - b0), 32'd3);
      chk("gl_rises", 32'(cnt_rise - r0), 32'd0);
      chk("gl_fe", 32'(cnt_fe - f0), 32'd0);
      chk("gl_ovr", 32'(cnt_ovr - o0), 32'd0);

      // reset during data bit 4, then a clean byte
      f0 = cnt_fe; r0 = cnt_rise;
      send(8'hFF, 1'b1, 1, 5);
      wait_cyc(10);
      chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_rises", 32'(cnt_rise - r0), 32'd0);
      chk("rst_mid_fe", 32'(cnt_fe - f0), 32'd0);
      send(8'h12, 1'b1, 1, -1);
      wait_cyc(5);
      chk("post_rst_data", 32'(rise_data), 32'h12);
      chk("post_rst_rises", 32'(cnt_rise - r0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
